// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared types and constants for the keyboard event controller.
//               Contains the decoder and IRQ state encodings, the PS/2 prefix
//               and control byte values, the 10-bit key event record, and a
//               helper that flags bytes the decoder ignores while idle.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // Decoder states for resolving the E0 / F0 / E1 prefix sequences
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } dec_state_e;

  // Interrupt sequencer states
  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_PULSE = 2'd1,
    IRQ_WAIT  = 2'd2
  } irq_state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // break (release) prefix
  localparam logic [7:0] BYTE_E1 = 8'hE1;  // pause-key prefix
  localparam logic [7:0] BYTE_12 = 8'h12;  // fake shift sent around extended keys
  localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] BYTE_FE = 8'hFE;  // resend request
  localparam logic [7:0] BYTE_EE = 8'hEE;  // echo

  // Key event as presented to the CPU: {ext[9], rel[8], code[7:0]}
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_evt_t;

  // Keyboard status/control responses that carry no key information
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
           (b == BYTE_EE) || (b == 8'h00)   || (b == 8'hFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_evt_fifo
// Description : Small synchronous FIFO holding decoded key events. The head
//               entry is always visible on head_o (zero when empty).
//               Ports: clk_i, rst_i (sync, active high), push_i/data_i write,
//               pop_i read, full_o, empty_o, head_o.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty
  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

  // A pop on an empty FIFO is ignored; a push into a full FIFO succeeds
  // only when the same cycle frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

  assign head_o = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[PW-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_event_ctrl
// Description : Turns raw PS/2 bytes into {ext, rel, code} key events, queues
//               them, and raises one fixed-length interrupt per pending event.
//               Ports: clk_i, rst_i (sync, active high), rx_done_i/rx_data_i
//               byte input, pop_i CPU read strobe, clr_ovf_i, evt_data_o head
//               event, evt_valid_o, intrpt_o, overflow_o (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INTR_CYCLES = 7,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       pop_i,
  input  logic       clr_ovf_i,
  output logic [9:0] evt_data_o,
  output logic       evt_valid_o,
  output logic       intrpt_o,
  output logic       overflow_o
);

  localparam int SW = $clog2(PAUSE_SKIP + 1);
  localparam int CW = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

  dec_state_e dec_q, dec_d;
  logic [SW-1:0] skip_q, skip_d;
  logic          push;
  kbd_evt_t      push_evt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf_q, ovf_d;

  irq_state_e    irq_q, irq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          popped_q, popped_d;

  // ---------------- prefix decoder ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_q  <= ST_IDLE;
      skip_q <= '0;
    end else begin
      dec_q  <= dec_d;
      skip_q <= skip_d;
    end
  end

  always_comb begin
    dec_d    = dec_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_evt = '0;
    if (rx_done_i) begin
      case (dec_q)
        ST_IDLE: begin
          if (rx_data_i == BYTE_E0) begin
            dec_d = ST_EXT;
          end else if (rx_data_i == BYTE_F0) begin
            dec_d = ST_BRK;
          end else if (rx_data_i == BYTE_E1) begin
            // Pause is reported once, then its fixed tail is swallowed
            dec_d    = ST_SKIP;
            skip_d   = SW'(PAUSE_SKIP);
            push     = 1'b1;
            push_evt = '{ext: 1'b1, rel: 1'b0, code: BYTE_E1};
          end else if (!is_ctrl_byte(rx_data_i)) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b0, rel: 1'b0, code: rx_data_i};
          end
        end
        ST_EXT: begin
          dec_d = ST_IDLE;
          if (rx_data_i == BYTE_F0) begin
            dec_d = ST_EXT_BRK;
          end else if (rx_data_i != BYTE_12) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b1, rel: 1'b0, code: rx_data_i};
          end
        end
        ST_BRK: begin
          dec_d    = ST_IDLE;
          push     = 1'b1;
          push_evt = '{ext: 1'b0, rel: 1'b1, code: rx_data_i};
        end
        ST_EXT_BRK: begin
          dec_d = ST_IDLE;
          if (rx_data_i != BYTE_12) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b1, rel: 1'b1, code: rx_data_i};
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == SW'(1)) begin
            dec_d = ST_IDLE;
          end
        end
        default: dec_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- event queue ----------------
  kbd_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_evt),
    .pop_i   (pop_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (evt_data_o)
  );

  assign evt_valid_o = !fifo_empty;

  // A simultaneous pop makes room, so only an unmatched push to a full FIFO
  // drops data. A new drop wins over a clear in the same cycle.
  always_comb begin
    ovf_d = clr_ovf_i ? 1'b0 : ovf_q;
    if (push && fifo_full && !pop_i) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;

  // ---------------- interrupt sequencer ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q    <= IRQ_IDLE;
      cnt_q    <= '0;
      popped_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
      popped_q <= popped_d;
    end
  end

  always_comb begin
    irq_d    = irq_q;
    cnt_d    = cnt_q;
    popped_d = popped_q;
    case (irq_q)
      IRQ_IDLE: begin
        popped_d = 1'b0;
        if (evt_valid_o) begin
          irq_d = IRQ_PULSE;
          cnt_d = '0;
        end
      end
      IRQ_PULSE: begin
        // A pop that arrives mid-pulse is remembered so the sequencer skips
        // the wait state and the next event gets its own pulse.
        if (pop_i) begin
          popped_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INTR_CYCLES - 1)) begin
          cnt_d = '0;
          irq_d = (popped_q || pop_i) ? IRQ_IDLE : IRQ_WAIT;
        end
      end
      IRQ_WAIT: begin
        if (pop_i) begin
          irq_d = IRQ_IDLE;
        end
      end
      default: irq_d = IRQ_IDLE;
    endcase
  end

  always_comb begin
    intrpt_o = (irq_q == IRQ_PULSE);
  end

endmodule
`default_nettype wire

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
- Sequencer between the PS/2 byte receiver and the CPU I/O bus.
- Consumes raw received bytes and resolves the E0 (extended), F0 (break) and E1 (pause) prefix sequences into single key events of the form {ext, rel, code}.
- Buffers events in a small FIFO and drives one interrupt per pending event. The CPU pops each event with a read strobe, so holding or releasing an extended key no longer produces spurious E0 interrupts.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, 2..16.
- INTR_CYCLES, 7, CLK cycles INTRPT is held high (70 ns at 100 MHz).
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  synchronous, active-high reset.
- RX_DONE  in  1  one-cycle strobe, byte valid on RX_DATA. Synchronous to CLK.
- RX_DATA  in  8  received byte.
- POP  in  1  CPU read strobe; removes the head event.
- CLR_OVF  in  1  clears OVERFLOW.
- EVT_DATA  out  10  head event {ext[9], rel[8], code[7:0]}.
- EVT_VALID  out  1  FIFO non-empty.
- INTRPT  out  1  interrupt pulse to CPU.
- OVERFLOW  out  1  sticky flag: event dropped because FIFO was full.

Behaviour:
- Reset (on the CLK edge with RST=1): decoder to ST_IDLE, skip counter 0, FIFO empty, IRQ FSM to IRQ_IDLE.
  - Outputs after reset: EVT_DATA=0, EVT_VALID=0, INTRPT=0, OVERFLOW=0.
  - A partially received prefix sequence is discarded.
- Decoder FSM acts only on cycles with RX_DONE=1.
  - ST_IDLE:
    - E0 -> ST_EXT.
    - F0 -> ST_BRK.
    - E1 -> ST_SKIP, load skip counter = PAUSE_SKIP, push {1,0,E1}.
    - AA, FA, FE, EE, 00, FF -> ignored, stay.
    - Any other byte -> push {0,0,byte}.
  - ST_EXT:
    - F0 -> ST_EXT_BRK.
    - 12 (fake shift) -> ST_IDLE, no push.
    - Any other byte -> push {1,0,byte}, ST_IDLE.
  - ST_BRK: push {0,1,byte}, ST_IDLE.
  - ST_EXT_BRK:
    - 12 -> ST_IDLE, no push.
    - Any other byte -> push {1,1,byte}, ST_IDLE.
  - ST_SKIP: each byte decrements the counter. The byte that brings it to 0 returns to ST_IDLE, no push.
  - A repeated E0 or F0 inside a prefix state is treated as an ordinary code byte (pushed as-is).
- Latency:
  - RX_DONE sampled on edge N -> entry written on edge N -> EVT_VALID=1 during cycle N+1.
  - INTRPT rises on edge N+1 (high from cycle N+2).
- FIFO:
  - Registered read and write pointers, each log2(DEPTH)+1 bits; wrap at DEPTH.
  - EVT_DATA always shows the head entry, 0 when empty.
  - Push when full: entry dropped, OVERFLOW<=1.
  - Push and POP in the same cycle when full: both occur, no overflow.
  - Push and POP in the same cycle when empty: push only; POP is ignored.
  - POP when empty: no effect.
  - OVERFLOW stays set until CLR_OVF. If CLR_OVF and a new overflow occur in the same cycle, OVERFLOW stays 1.
- IRQ FSM:
  - IRQ_IDLE: if EVT_VALID -> IRQ_PULSE with counter=0.
  - IRQ_PULSE: INTRPT=1; once the counter reaches INTR_CYCLES-1 -> IRQ_WAIT.
  - IRQ_WAIT: INTRPT=0; on POP -> IRQ_IDLE.
  - After a POP that leaves the FIFO non-empty, INTRPT is low for at least 1 cycle before the next pulse.
  - A POP during IRQ_PULSE finishes the pulse, then goes to IRQ_IDLE.
  - Exactly one interrupt per popped event. An event pushed while in IRQ_WAIT does not raise an extra pulse.
- All arithmetic is unsigned; counters saturate nowhere because their ranges are fixed by parameters.

Decomposition:
- Package kbd_pkg:
  - Decoder state enum.
  - IRQ state enum.
  - Byte constants: E0, F0, E1, 12, AA, FA, FE, EE.
  - 10-bit event struct {ext, rel, code}.
- One sub-module: kbd_evt_fifo (parameterised DEPTH, WIDTH=10, push/pop/full/empty/head).
- Decoder and IRQ FSMs live in the top module.

Test Plan:
- Byte 1C -> one event 01C, EVT_VALID=1 in the next cycle; INTRPT high exactly 7 cycles; POP -> EVT_VALID=0, no further pulse.
- Bytes E0 75, then E0 F0 75 with a POP after each interrupt -> events 275, then 375; exactly 2 INTRPT pulses, none for the prefix bytes.
- Bytes F0 1C, then AA, then FA -> single event 11C; AA and FA produce nothing.
- E1 14 77 E1 F0 14 F0 77, then 1C -> events 2E1 and 01C only; the skip counter returns the decoder to ST_IDLE.
- Six key codes 15, 16, 1E, 26, 25, 2E with no POP (DEPTH=4) -> first four retained in order, OVERFLOW=1, single INTRPT. Four POPs yield 015, 016, 01E, 026, with one pulse before each remaining event. CLR_OVF -> OVERFLOW=0.
- RST asserted after E0 has been received, then byte 75 -> event 075 (extended flag lost); all outputs 0 in the cycle after the reset edge.
